// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC model store: model order, FP constant, state enum, index type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lpc_pkg;

  localparam int ORDER_MAX = 12;

  // IEEE-754 single-precision 1.0, the fixed a[0] of every fresh model.
  localparam logic [31:0] FP_ONE = 32'h3f80_0000;

  typedef logic [3:0] lpc_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_READOUT = 2'd2
  } store_state_t;

endpackage

// File: rtl/model_store_if.sv
// Bus between ModelSelector/quantiser side (master) and the coefficient store (slave).
// Latency: n/a (wires only).
// Backpressure: none; the stream has no ready, the consumer must take every valid word.
// Ports: init/select/write-back/commit/readout-request from master; read data, stream and status from slave.
interface model_store_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);

  logic              iInit;
  logic [IDX_W-1:0]  iSel1;
  logic [IDX_W-1:0]  iSel2;
  logic [DATA_W-1:0] oModel1;
  logic [DATA_W-1:0] oModel2;
  logic              iValid;
  logic              iOnlyOne;
  logic [IDX_W-1:0]  iTarget1;
  logic [IDX_W-1:0]  iTarget2;
  logic [DATA_W-1:0] iNewModel1;
  logic [DATA_W-1:0] iNewModel2;
  logic              iCommit;
  logic [IDX_W-1:0]  iM;
  logic [DATA_W-1:0] iKm;
  logic              iReadStart;
  logic [IDX_W-1:0]  iReadOrder;
  logic [DATA_W-1:0] oCoef;
  logic [IDX_W-1:0]  oCoefIdx;
  logic              oCoefValid;
  logic              oCoefLast;
  logic              oBusy;
  logic              oReady;

  modport master (
    output iInit, iSel1, iSel2, iValid, iOnlyOne, iTarget1, iTarget2,
           iNewModel1, iNewModel2, iCommit, iM, iKm, iReadStart, iReadOrder,
    input  oModel1, oModel2, oCoef, oCoefIdx, oCoefValid, oCoefLast, oBusy, oReady
  );

  modport slave (
    input  iInit, iSel1, iSel2, iValid, iOnlyOne, iTarget1, iTarget2,
           iNewModel1, iNewModel2, iCommit, iM, iKm, iReadStart, iReadOrder,
    output oModel1, oModel2, oCoef, oCoefIdx, oCoefValid, oCoefLast, oBusy, oReady
  );

endinterface

// File: rtl/model_regfile.sv
// Register array a[0..ORDER_MAX] with three async reads, two write-back ports, a commit port and init load.
// Latency: reads 0 cycles, writes visible after 1 edge.
// Backpressure: none; writes outside wr_en are dropped.
// Ports: clk/rst, init, wr_en gate, rd1/rd2/rd3 idx->dat, wr1/wr2 vld/idx/dat, km vld/idx/dat.
module model_regfile
  import lpc_pkg::*;
#(
  parameter int ORDER_MAX = lpc_pkg::ORDER_MAX,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  rd1_idx,
  input  logic [IDX_W-1:0]  rd2_idx,
  input  logic [IDX_W-1:0]  rd3_idx,
  output logic [DATA_W-1:0] rd1_dat,
  output logic [DATA_W-1:0] rd2_dat,
  output logic [DATA_W-1:0] rd3_dat,
  input  logic              wr1_vld,
  input  logic [IDX_W-1:0]  wr1_idx,
  input  logic [DATA_W-1:0] wr1_dat,
  input  logic              wr2_vld,
  input  logic [IDX_W-1:0]  wr2_idx,
  input  logic [DATA_W-1:0] wr2_dat,
  input  logic              km_vld,
  input  logic [IDX_W-1:0]  km_idx,
  input  logic [DATA_W-1:0] km_dat
);

  logic [DATA_W-1:0] mem_q [ORDER_MAX+1];
  logic [DATA_W-1:0] mem_d [ORDER_MAX+1];

  // Loop starts at 1 so a[0] and out-of-range targets are never written.
  // Later assignments win: port 2, then port 1, then the commit.
  always_comb begin
    mem_d = mem_q;
    if (init) begin
      for (int i = 0; i <= ORDER_MAX; i++) begin
        mem_d[i] = '0;
      end
      mem_d[0] = DATA_W'(FP_ONE);
    end else if (wr_en) begin
      for (int i = 1; i <= ORDER_MAX; i++) begin
        if (wr2_vld && (wr2_idx == IDX_W'(i))) mem_d[i] = wr2_dat;
        if (wr1_vld && (wr1_idx == IDX_W'(i))) mem_d[i] = wr1_dat;
        if (km_vld  && (km_idx  == IDX_W'(i))) mem_d[i] = km_dat;
      end
    end
  end

  // Index beyond ORDER_MAX matches no entry and reads 0.
  always_comb begin
    rd1_dat = '0;
    rd2_dat = '0;
    rd3_dat = '0;
    for (int i = 0; i <= ORDER_MAX; i++) begin
      if (rd1_idx == IDX_W'(i)) rd1_dat = mem_q[i];
      if (rd2_idx == IDX_W'(i)) rd2_dat = mem_q[i];
      if (rd3_idx == IDX_W'(i)) rd3_dat = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ORDER_MAX; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/model_store.sv
// LPC coefficient store: serves ModelSelector reads/write-backs, km commits, then streams a[1..p].
// Latency: reads 0 cycles, writes 1 edge, first stream word the cycle after iReadStart is sampled.
// Backpressure: none; the stream emits p words back to back, iInit aborts it.
// Ports: iClock/iReset plain; everything else on model_store_if.slave (see interface).
module model_store
  import lpc_pkg::*;
#(
  parameter int ORDER_MAX = lpc_pkg::ORDER_MAX,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 4
) (
  input  logic         iClock,
  input  logic         iReset,
  model_store_if.slave bus
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ORDER_MAX);

  store_state_t     state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] rd_order_q, rd_order_d;
  logic             coef_vld_q, coef_vld_d;
  logic             coef_last_q, coef_last_d;
  logic [DATA_W-1:0] rd_coef;
  logic             start_ok;

  assign start_ok = bus.iReadStart && (bus.iReadOrder != '0) && (bus.iReadOrder <= MAX_IDX);

  model_regfile #(
    .ORDER_MAX(ORDER_MAX),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk    (iClock),
    .rst    (iReset),
    .init   (bus.iInit),
    .wr_en  (state_q == ST_ACTIVE),
    .rd1_idx(bus.iSel1),
    .rd2_idx(bus.iSel2),
    .rd3_idx(rd_idx_q),
    .rd1_dat(bus.oModel1),
    .rd2_dat(bus.oModel2),
    .rd3_dat(rd_coef),
    .wr1_vld(bus.iValid),
    .wr1_idx(bus.iTarget1),
    .wr1_dat(bus.iNewModel1),
    .wr2_vld(bus.iValid && !bus.iOnlyOne),
    .wr2_idx(bus.iTarget2),
    .wr2_dat(bus.iNewModel2),
    .km_vld (bus.iCommit),
    .km_idx (bus.iM),
    .km_dat (bus.iKm)
  );

  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    rd_order_d  = rd_order_q;
    coef_vld_d  = coef_vld_q;
    coef_last_d = coef_last_q;
    if (bus.iInit) begin
      state_d     = ST_ACTIVE;
      rd_idx_d    = '0;
      coef_vld_d  = 1'b0;
      coef_last_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (start_ok) begin
            state_d     = ST_READOUT;
            rd_idx_d    = IDX_W'(1);
            rd_order_d  = bus.iReadOrder;
            coef_vld_d  = 1'b1;
            coef_last_d = (bus.iReadOrder == IDX_W'(1));
          end
        end
        ST_READOUT: begin
          if (coef_last_q) begin
            state_d     = ST_ACTIVE;
            rd_idx_d    = '0;
            coef_vld_d  = 1'b0;
            coef_last_d = 1'b0;
          end else begin
            rd_idx_d    = rd_idx_q + IDX_W'(1);
            coef_last_d = ((rd_idx_q + IDX_W'(1)) == rd_order_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      rd_idx_q    <= '0;
      rd_order_q  <= '0;
      coef_vld_q  <= 1'b0;
      coef_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      rd_order_q  <= rd_order_d;
      coef_vld_q  <= coef_vld_d;
      coef_last_q <= coef_last_d;
    end
  end

  // Array is frozen during READOUT, so reading the word live through the
  // third port is equivalent to registering it and also reflects any write
  // taken on the start edge.
  assign bus.oCoef      = coef_vld_q ? rd_coef : '0;
  assign bus.oCoefIdx   = rd_idx_q;
  assign bus.oCoefValid = coef_vld_q;
  assign bus.oCoefLast  = coef_last_q;
  assign bus.oBusy      = (state_q == ST_READOUT);
  assign bus.oReady     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_model_store.sv
module tb_model_store;
  import lpc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  model_store_if bus ();

  model_store dut (
    .iClock(clk),
    .iReset(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: array contents plus mode (0 idle, 1 active, 2 streaming),
  // the word number currently shown and the requested order.
  logic [31:0] ra [13];
  int          mode;
  int          rk;
  int          rp;
  logic [39:0] exp_outs;   // {vld, last, busy, ready, idx[3:0], coef[31:0]}
  logic [39:0] got_outs;

  function automatic logic [31:0] ref_rd(input logic [3:0] s);
    int k;
    k = int'(s);
    return (k <= 12) ? ra[k] : 32'h0;
  endfunction

  task automatic model_outs();
    logic [3:0] idx;
    idx = (mode == 2) ? 4'(rk) : 4'd0;
    exp_outs = {mode == 2, (mode == 2) && (rk == rp), mode == 2, mode == 1, idx,
                (mode == 2) ? ra[rk] : 32'h0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 13; i++) ra[i] = 32'h0;
    mode = 0;
    rk   = 0;
    rp   = 0;
    model_outs();
  endtask

  task automatic model_edge();
    int t1, t2, m, p;
    t1 = int'(bus.iTarget1);
    t2 = int'(bus.iTarget2);
    m  = int'(bus.iM);
    p  = int'(bus.iReadOrder);
    if (bus.iInit) begin
      for (int i = 0; i < 13; i++) ra[i] = 32'h0;
      ra[0] = 32'h3f800000;
      mode = 1;
      rk = 0;
    end else if (mode == 1) begin
      if (bus.iValid && !bus.iOnlyOne && t2 >= 1 && t2 <= 12) ra[t2] = bus.iNewModel2;
      if (bus.iValid && t1 >= 1 && t1 <= 12) ra[t1] = bus.iNewModel1;
      if (bus.iCommit && m >= 1 && m <= 12) ra[m] = bus.iKm;
      if (bus.iReadStart && p >= 1 && p <= 12) begin
        mode = 2;
        rk = 1;
        rp = p;
      end
    end else if (mode == 2) begin
      if (rk == rp) begin
        mode = 1;
        rk = 0;
      end else begin
        rk++;
      end
    end
    model_outs();
  endtask

  task automatic clr();
    bus.iInit = 0; bus.iValid = 0; bus.iOnlyOne = 0; bus.iCommit = 0; bus.iReadStart = 0;
    bus.iTarget1 = 0; bus.iTarget2 = 0; bus.iNewModel1 = 0; bus.iNewModel2 = 0;
    bus.iM = 0; bus.iKm = 0; bus.iReadOrder = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    bus.iSel1 = 4'd0;
    bus.iSel2 = 4'd1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got_outs = {bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady, bus.oCoefIdx, bus.oCoef};
    checks++;
    if (got_outs !== 40'h0) begin
      errors++; $display("FAIL reset_outs got %h exp %h", got_outs, 40'h0);
    end
    checks++;
    if (bus.oModel1 !== 32'h0) begin
      errors++; $display("FAIL reset_a0 got %h exp %h", bus.oModel1, 32'h0);
    end
    rst = 1'b0;
    // Writes before the first iInit must be dropped.
    bus.iValid = 1; bus.iTarget1 = 4'd1; bus.iNewModel1 = 32'h12345678;
    step();
    clr();
    checks++;
    if (bus.oModel2 !== 32'h0 || bus.oReady !== 1'b0) begin
      errors++; $display("FAIL idle_write got %h/%b exp 0/0", bus.oModel2, bus.oReady);
    end
  endtask

  task automatic test_init();
    clr();
    bus.iInit = 1;
    bus.iSel1 = 4'd0;
    bus.iSel2 = 4'd1;
    step();
    clr();
    checks++;
    if (bus.oModel1 !== 32'h3f800000) begin
      errors++; $display("FAIL init_a0 got %h exp 3f800000", bus.oModel1);
    end
    checks++;
    if (bus.oModel2 !== 32'h0) begin
      errors++; $display("FAIL init_a1 got %h exp 0", bus.oModel2);
    end
    checks++;
    if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0) begin
      errors++; $display("FAIL init_ready got %b/%b exp 1/0", bus.oReady, bus.oBusy);
    end
  endtask

  task automatic test_order2();
    clr();
    bus.iCommit = 1; bus.iM = 4'd1; bus.iKm = 32'hbf7f7cee;
    step();
    clr();
    bus.iValid = 1; bus.iOnlyOne = 1; bus.iTarget1 = 4'd1; bus.iNewModel1 = 32'hbf7f7cee;
    bus.iTarget2 = 4'd2; bus.iNewModel2 = 32'hdeadbeef;
    step();
    clr();
    bus.iSel1 = 4'd2;
    #1;
    checks++;
    if (bus.oModel1 !== 32'h0) begin
      errors++; $display("FAIL onlyone_a2 got %h exp 0", bus.oModel1);
    end
    bus.iCommit = 1; bus.iM = 4'd2; bus.iKm = 32'h3f6be0df;
    step();
    clr();
    bus.iSel1 = 4'd1;
    bus.iSel2 = 4'd2;
    #1;
    checks++;
    if (bus.oModel1 !== 32'hbf7f7cee) begin
      errors++; $display("FAIL order2_a1 got %h exp bf7f7cee", bus.oModel1);
    end
    checks++;
    if (bus.oModel2 !== 32'h3f6be0df) begin
      errors++; $display("FAIL order2_a2 got %h exp 3f6be0df", bus.oModel2);
    end
  endtask

  task automatic test_conflicts();
    clr();
    bus.iValid = 1; bus.iTarget1 = 4'd3; bus.iTarget2 = 4'd3;
    bus.iNewModel1 = 32'h11111111; bus.iNewModel2 = 32'h22222222;
    bus.iSel1 = 4'd3;
    #1;
    checks++;
    if (bus.oModel1 !== 32'h0) begin
      errors++; $display("FAIL write_early got %h exp 0", bus.oModel1);
    end
    step();
    checks++;
    if (bus.oModel1 !== 32'h11111111) begin
      errors++; $display("FAIL port1_wins got %h exp 11111111", bus.oModel1);
    end
    bus.iNewModel1 = 32'h44444444;
    bus.iCommit = 1; bus.iM = 4'd3; bus.iKm = 32'h33333333;
    step();
    checks++;
    if (bus.oModel1 !== 32'h33333333) begin
      errors++; $display("FAIL commit_wins got %h exp 33333333", bus.oModel1);
    end
    clr();
    bus.iValid = 1; bus.iTarget1 = 4'd0; bus.iTarget2 = 4'd0;
    bus.iNewModel1 = 32'h55555555; bus.iNewModel2 = 32'h66666666;
    bus.iCommit = 1; bus.iM = 4'd0; bus.iKm = 32'h77777777;
    bus.iSel1 = 4'd0;
    step();
    clr();
    checks++;
    if (bus.oModel1 !== 32'h3f800000) begin
      errors++; $display("FAIL a0_immutable got %h exp 3f800000", bus.oModel1);
    end
  endtask

  task automatic test_readout3();
    logic [31:0] vals [4];
    vals[0] = 32'h0; vals[1] = 32'ha1a1a1a1; vals[2] = 32'hb2b2b2b2; vals[3] = 32'hc3c3c3c3;
    clr();
    bus.iValid = 1; bus.iTarget1 = 4'd1; bus.iNewModel1 = vals[1];
    bus.iTarget2 = 4'd2; bus.iNewModel2 = vals[2];
    step();
    clr();
    bus.iValid = 1; bus.iOnlyOne = 1; bus.iTarget1 = 4'd3; bus.iNewModel1 = vals[3];
    step();
    clr();
    bus.iReadStart = 1; bus.iReadOrder = 4'd3;
    step();
    clr();
    for (int w = 1; w <= 3; w++) begin
      got_outs = {bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady, bus.oCoefIdx, bus.oCoef};
      checks++;
      if (got_outs !== {1'b1, w == 3, 1'b1, 1'b0, 4'(w), vals[w]}) begin
        errors++; $display("FAIL rd3_word%0d got %h exp %h", w, got_outs,
                           {1'b1, w == 3, 1'b1, 1'b0, 4'(w), vals[w]});
      end
      step();
    end
    checks++;
    if (bus.oCoefValid !== 1'b0 || bus.oReady !== 1'b1 || bus.oBusy !== 1'b0) begin
      errors++; $display("FAIL rd3_done got v%b r%b b%b exp v0 r1 b0",
                         bus.oCoefValid, bus.oReady, bus.oBusy);
    end
  endtask

  task automatic test_init_abort();
    logic [31:0] snap [13];
    clr();
    for (int k = 1; k <= 12; k += 2) begin
      bus.iValid = 1;
      bus.iTarget1 = 4'(k);     bus.iNewModel1 = $urandom | 32'h1;
      bus.iTarget2 = 4'(k + 1); bus.iNewModel2 = $urandom | 32'h1;
      step();
    end
    clr();
    for (int i = 0; i < 13; i++) snap[i] = ra[i];
    bus.iReadStart = 1; bus.iReadOrder = 4'd12;
    step();
    for (int w = 1; w <= 5; w++) begin
      clr();
      checks++;
      if ({bus.oCoefValid, bus.oCoefLast, bus.oCoefIdx, bus.oCoef} !== {2'b10, 4'(w), snap[w]}) begin
        errors++; $display("FAIL rd12_word%0d got %h exp %h", w,
                           {bus.oCoefValid, bus.oCoefLast, bus.oCoefIdx, bus.oCoef},
                           {2'b10, 4'(w), snap[w]});
      end
      if (w == 2) begin
        bus.iValid = 1; bus.iTarget1 = 4'd4; bus.iNewModel1 = 32'hffffffff;
        bus.iTarget2 = 4'd6; bus.iNewModel2 = 32'heeeeeeee;
        bus.iCommit = 1; bus.iM = 4'd5; bus.iKm = 32'hdddddddd;
        bus.iReadStart = 1; bus.iReadOrder = 4'd2;
      end
      if (w == 3) begin
        bus.iSel1 = 4'd4;
        bus.iSel2 = 4'd6;
        #1;
        checks++;
        if (bus.oModel1 !== snap[4] || bus.oModel2 !== snap[6]) begin
          errors++; $display("FAIL rd_write_drop got %h/%h exp %h/%h",
                             bus.oModel1, bus.oModel2, snap[4], snap[6]);
        end
      end
      if (w == 5) bus.iInit = 1;
      step();
    end
    clr();
    checks++;
    if ({bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady} !== 4'b0001) begin
      errors++; $display("FAIL abort_flags got %b exp 0001",
                         {bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady});
    end
    bus.iSel1 = 4'd12;
    bus.iSel2 = 4'd0;
    #1;
    checks++;
    if (bus.oModel1 !== 32'h0 || bus.oModel2 !== 32'h3f800000) begin
      errors++; $display("FAIL abort_array got %h/%h exp 0/3f800000", bus.oModel1, bus.oModel2);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    bus.iValid = 1; bus.iTarget1 = 4'd1; bus.iNewModel1 = 32'h0badf00d;
    bus.iTarget2 = 4'd2; bus.iNewModel2 = 32'hcafef00d;
    step();
    clr();
    bus.iReadStart = 1; bus.iReadOrder = 4'd2;
    step();
    clr();
    bus.iSel1 = 4'd1;
    #1;
    checks++;
    if (bus.oCoefValid !== 1'b1 || bus.oCoef !== 32'h0badf00d) begin
      errors++; $display("FAIL pre_reset_word got %b/%h exp 1/0badf00d", bus.oCoefValid, bus.oCoef);
    end
    rst = 1'b1;
    model_reset();
    #1;
    got_outs = {bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady, bus.oCoefIdx, bus.oCoef};
    checks++;
    if (got_outs !== 40'h0 || bus.oModel1 !== 32'h0) begin
      errors++; $display("FAIL async_reset got %h/%h exp 0/0", got_outs, bus.oModel1);
    end
    rst = 1'b0;
    bus.iValid = 1; bus.iTarget1 = 4'd1; bus.iNewModel1 = 32'h99999999;
    bus.iReadStart = 1; bus.iReadOrder = 4'd1;
    step();
    clr();
    checks++;
    if (bus.oModel1 !== 32'h0 || bus.oCoefValid !== 1'b0 || bus.oReady !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got %h/%b/%b exp 0/0/0",
                         bus.oModel1, bus.oCoefValid, bus.oReady);
    end
    bus.iInit = 1;
    step();
    clr();
    checks++;
    if (bus.oReady !== 1'b1) begin
      errors++; $display("FAIL reinit_ready got %b exp 1", bus.oReady);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
      end
      bus.iInit      = ($urandom_range(0, 39) == 0);
      bus.iValid     = $urandom_range(0, 1);
      bus.iOnlyOne   = ($urandom_range(0, 2) == 0);
      bus.iTarget1   = 4'($urandom_range(0, 15));
      bus.iTarget2   = 4'($urandom_range(0, 15));
      bus.iNewModel1 = $urandom;
      bus.iNewModel2 = $urandom;
      bus.iCommit    = ($urandom_range(0, 3) == 0);
      bus.iM         = 4'($urandom_range(0, 15));
      bus.iKm        = $urandom;
      bus.iReadStart = ($urandom_range(0, 9) == 0);
      bus.iReadOrder = 4'($urandom_range(0, 15));
      bus.iSel1      = 4'($urandom_range(0, 15));
      bus.iSel2      = 4'($urandom_range(0, 15));
      step();
      got_outs = {bus.oCoefValid, bus.oCoefLast, bus.oBusy, bus.oReady, bus.oCoefIdx, bus.oCoef};
      checks++;
      if (got_outs !== exp_outs) begin
        errors++; $display("FAIL rand_stream c%0d got %h exp %h", c, got_outs, exp_outs);
      end
      checks++;
      if (bus.oModel1 !== ref_rd(bus.iSel1)) begin
        errors++; $display("FAIL rand_model1 c%0d sel %0d got %h exp %h", c, bus.iSel1,
                           bus.oModel1, ref_rd(bus.iSel1));
      end
      checks++;
      if (bus.oModel2 !== ref_rd(bus.iSel2)) begin
        errors++; $display("FAIL rand_model2 c%0d sel %0d got %h exp %h", c, bus.iSel2,
                           bus.oModel2, ref_rd(bus.iSel2));
      end
    end
    clr();
  endtask

  initial begin
    clr();
    bus.iSel1 = 4'd0;
    bus.iSel2 = 4'd0;
    model_reset();
    test_reset();
    test_init();
    test_order2();
    test_conflicts();
    test_readout3();
    test_init_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
